ex_mem_ccr_stage: RTL and testbench

EX_MEM_CCR_STAGE -- requirements
Module: ex_mem_ccr_stage

---
 rtl/ex_mem_ccr_stage.sv | 75 +++++++
 tb/tb_ex_mem_ccr_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_ccr_stage.sv
// EX/MEM pipeline register plus the architectural condition-code register (Z,N,C)
// and its single-level interrupt shadow copy.
module ex_mem_ccr_stage #(
  parameter int WIDTH = 16,
  parameter int RADDR = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       alu_flag,
  input  logic [2:0]       flag_we,
  input  logic             ex_valid,
  input  logic [RADDR-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             stall,
  input  logic             flush,
  input  logic             ccr_save,
  input  logic             ccr_restore,
  output logic [WIDTH-1:0] mem_alu_out,
  output logic [RADDR-1:0] mem_rd,
  output logic             mem_reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_valid,
  output logic [2:0]       ccr
);

  // Transfer rule: an instruction moves EX->MEM when ex_valid is high and the
  // stage is neither stalled nor flushed; flush beats stall, stall beats load.
  logic       acc;
  logic [2:0] ccr_nxt;
  logic [2:0] shadow;

  assign acc     = ex_valid & ~stall & ~flush;
  assign ccr_nxt = acc ? ((ccr & ~flag_we) | (alu_flag & flag_we)) : ccr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_alu_out   <= '0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_valid     <= 1'b0;
    end else if (flush) begin
      mem_alu_out   <= '0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_valid     <= 1'b0;
    end else if (!stall) begin
      mem_alu_out   <= alu_out;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write & ex_valid;
      mem_read      <= ex_mem_read & ex_valid;
      mem_write     <= ex_mem_write & ex_valid;
      mem_valid     <= ex_valid;
    end
  end

  // Restore overrides the ALU path; a concurrent save is dropped so the shadow holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr    <= 3'b000;
      shadow <= 3'b000;
    end else begin
      ccr <= ccr_restore ? shadow : ccr_nxt;
      if (ccr_save && !ccr_restore) shadow <= ccr_nxt;
    end
  end

endmodule

// File: tb/tb_ex_mem_ccr_stage.sv
// Self-checking bench for ex_mem_ccr_stage: directed scenarios plus a random run,
// with a reference model feeding an expected-value queue.
module tb_ex_mem_ccr_stage;

  localparam int WIDTH = 16;
  localparam int RADDR = 3;
  localparam int W     = 4 + RADDR + WIDTH + 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] alu_out;
  logic [2:0]       alu_flag;
  logic [2:0]       flag_we;
  logic             ex_valid;
  logic [RADDR-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_mem_write;
  logic             stall;
  logic             flush;
  logic             ccr_save;
  logic             ccr_restore;
  logic [WIDTH-1:0] mem_alu_out;
  logic [RADDR-1:0] mem_rd;
  logic             mem_reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             mem_valid;
  logic [2:0]       ccr;

  ex_mem_ccr_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk(clk), .rst_n(rst_n), .alu_out(alu_out), .alu_flag(alu_flag),
    .flag_we(flag_we), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .stall(stall), .flush(flush),
    .ccr_save(ccr_save), .ccr_restore(ccr_restore),
    .mem_alu_out(mem_alu_out), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_valid(mem_valid), .ccr(ccr)
  );

  // Clock and observation vector: {valid, reg_write, read, write, rd, alu_out, ccr}
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] obs;
  assign obs = {mem_valid, mem_reg_write, mem_read, mem_write, mem_rd, mem_alu_out, ccr};

  // Scoreboard state
  logic [W-1:0]             exp_q[$];
  logic [W-1:0]             exp_v;
  logic [W-1:0]             held;
  logic [4+RADDR+WIDTH-1:0] m_pipe;
  logic [2:0]               m_ccr;
  logic [2:0]               m_shadow;
  int                       n_cmp;
  int                       n_fail;

  task automatic model_reset();
    m_pipe   = '0;
    m_ccr    = 3'b000;
    m_shadow = 3'b000;
  endtask

  task automatic idle_inputs();
    alu_out = '0; alu_flag = '0; flag_we = '0; ex_valid = 0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    stall = 0; flush = 0; ccr_save = 0; ccr_restore = 0;
  endtask

  task automatic set_instr(input logic [WIDTH-1:0] a, input logic [2:0] f,
                           input logic [2:0] we, input logic v, input logic [RADDR-1:0] rd,
                           input logic rw, input logic mr, input logic mw);
    alu_out = a; alu_flag = f; flag_we = we; ex_valid = v; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
  endtask

  // Driver: predicts the next state from current inputs, pushes it, advances one edge.
  task automatic step();
    logic       acc;
    logic [2:0] cn;
    acc = ex_valid & ~stall & ~flush;
    cn  = m_ccr;
    if (acc)
      for (int i = 0; i < 3; i++)
        if (flag_we[i]) cn[i] = alu_flag[i];
    if (flush)
      m_pipe = '0;
    else if (!stall)
      m_pipe = {ex_valid, ex_reg_write & ex_valid, ex_mem_read & ex_valid,
                ex_mem_write & ex_valid, ex_rd, alu_out};
    if (ccr_save && !ccr_restore) m_shadow = cn;
    m_ccr = ccr_restore ? m_ccr_restore_src() : cn;
    exp_q.push_back({m_pipe, m_ccr});
    @(posedge clk);
    #1;
  endtask

  logic [2:0] shadow_before;
  function automatic logic [2:0] m_ccr_restore_src();
    return shadow_before;
  endfunction

  // Wraps step so that restore sees the shadow value from before this edge.
  task automatic cycle();
    shadow_before = m_shadow;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, {W{1'b0}});
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_load();
    set_instr(16'h0100, 3'b000, 3'b111, 1, 3'd3, 1, 0, 0);
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_sb: got %h want %h", obs, exp_v);
    end
    n_cmp++;
    if ({mem_valid, mem_reg_write, mem_read, mem_write, mem_rd, mem_alu_out, ccr} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 16'h0100, 3'b000}) begin
      n_fail++;
      $display("FAIL load_direct: got %h", obs);
    end
    // Invalid instruction: data loads, controls forced low
    set_instr(16'hBEEF, 3'b111, 3'b111, 0, 3'd5, 1, 1, 1);
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL load_invalid: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_partial();
    logic [2:0] want[2];
    logic [2:0] we[2];
    want[0] = 3'b001; want[1] = 3'b101;
    we[0]   = 3'b001; we[1]   = 3'b100;
    for (int i = 0; i < 2; i++) begin
      set_instr(16'h0010 + 16'(i), 3'b101, we[i], 1, 3'd1, 1, 0, 0);
      cycle();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v || ccr !== want[i]) begin
        n_fail++;
        $display("FAIL partial_we%0d: got obs %h ccr %b want obs %h ccr %b",
                 i, obs, ccr, exp_v, want[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    set_instr(16'h1234, 3'b010, 3'b111, 1, 3'd6, 0, 1, 0);
    cycle();
    exp_v = exp_q.pop_front();
    held  = obs;
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL stall_setup: got %h want %h", obs, exp_v);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(16'hA000 + 16'(i), 3'(i + 4), 3'b111, 1, 3'(i), 1, 0, 1);
      cycle();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v || obs !== held) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h want %h", i, obs, held);
      end
    end
    flush = 1;
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || obs !== {{(4 + RADDR + WIDTH){1'b0}}, held[2:0]}) begin
      n_fail++;
      $display("FAIL stall_flush: got %h want %h", obs, exp_v);
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_save_restore();
    set_instr(16'h0001, 3'b010, 3'b111, 1, 3'd2, 1, 0, 0);
    cycle();
    void'(exp_q.pop_front());
    set_instr(16'h0002, 3'b101, 3'b111, 1, 3'd2, 1, 0, 0);
    ccr_save = 1;
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || ccr !== 3'b101) begin
      n_fail++;
      $display("FAIL save_ccr: got %h want %h", obs, exp_v);
    end
    ccr_save = 0;
    set_instr(16'h0003, 3'b000, 3'b111, 1, 3'd2, 1, 0, 0);
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || ccr !== 3'b000) begin
      n_fail++;
      $display("FAIL clear_ccr: got %h want %h", obs, exp_v);
    end
    // Restore while stalled and flushed, with a competing ALU update
    set_instr(16'h0004, 3'b011, 3'b111, 1, 3'd2, 1, 0, 0);
    stall = 1; flush = 1; ccr_restore = 1;
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || ccr !== 3'b101) begin
      n_fail++;
      $display("FAIL restore: got %h want %h", obs, exp_v);
    end
    stall = 0; flush = 0; ccr_restore = 0;
    // Save and restore together: ccr takes old shadow, shadow keeps 101
    set_instr(16'h0005, 3'b011, 3'b111, 1, 3'd2, 1, 0, 0);
    cycle();
    void'(exp_q.pop_front());
    set_instr(16'h0006, 3'b110, 3'b111, 1, 3'd2, 1, 0, 0);
    ccr_save = 1; ccr_restore = 1;
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || ccr !== 3'b101) begin
      n_fail++;
      $display("FAIL save_restore_both: got %h want %h", obs, exp_v);
    end
    ccr_save = 0; ccr_restore = 0;
    set_instr(16'h0007, 3'b000, 3'b111, 1, 3'd2, 1, 0, 0);
    cycle();
    void'(exp_q.pop_front());
    ccr_restore = 1; ex_valid = 0;
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || ccr !== 3'b101) begin
      n_fail++;
      $display("FAIL shadow_held: got %h want %h", obs, exp_v);
    end
    ccr_restore = 0;
  endtask

  task automatic test_async_reset();
    set_instr(16'h5A5A, 3'b111, 3'b111, 1, 3'd7, 1, 1, 1);
    cycle();
    void'(exp_q.pop_front());
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_valid !== 1'b0 || ccr !== 3'b000 || obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want %h", obs, {W{1'b0}});
    end
    model_reset();
    #2 rst_n = 1'b1;
    set_instr(16'hC0DE, 3'b100, 3'b110, 1, 3'd4, 1, 0, 1);
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v ||
        {mem_valid, mem_alu_out, ccr} !== {1'b1, 16'hC0DE, 3'b100}) begin
      n_fail++;
      $display("FAIL post_reset_load: got %h want %h", obs, exp_v);
    end
    idle_inputs();
    ccr_restore = 1;
    cycle();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (obs !== exp_v || ccr !== 3'b000) begin
      n_fail++;
      $display("FAIL shadow_cleared: got %h want %h", obs, exp_v);
    end
    ccr_restore = 0;
  endtask

  task automatic test_back_to_back();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      set_instr(16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
                3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      stall       = ($urandom_range(0, 4) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      ccr_save    = ($urandom_range(0, 9) == 0);
      ccr_restore = ($urandom_range(0, 9) == 0);
      cycle();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d: got %h want %h", i, obs, exp_v);
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_load();
    test_partial();
    test_stall_flush();
    test_save_restore();
    test_async_reset();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
